// File: rtl/instruction_fetch_unit.sv
// Fetch stage for the 16-bit multicycle CPU. It holds the PC, reads instruction memory over a
// req/ack handshake of variable latency, and hands each fetched word to the IR with a 1-cycle IRWrite pulse.
module instruction_fetch_unit #(
    parameter int ADDR_W   = 16,
    parameter int PC_STEP  = 2,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [15:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [15:0]       memData,
    output logic              IRWrite,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_inst,
    output logic              busy,
    output logic              fault,
    output logic [1:0]        dbg_state_o
);

    // Memory handshake: mem_rd rises one cycle after fetch_en is taken in IDLE and
    // stays high with a stable mem_addr until the cycle in which mem_ack is seen,
    // or until the timeout abort. mem_ack is a 1-cycle pulse and is ignored in IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inst_q, pc_inst_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic [15:0]       mem_data_q, mem_data_d;
    logic              ir_write_q, ir_write_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] target;
    logic              misaligned;

    always_comb begin
        target     = redirect_pc;
        misaligned = 1'b0;
        if (PC_STEP == 2) begin
            target[0]  = 1'b0;
            misaligned = redirect_pc[0];
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_inst_d  = pc_inst_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        mem_data_d = mem_data_q;
        ir_write_d = 1'b0;
        fault_d    = fault_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (redirect) begin
                    pc_d = target;
                    if (misaligned) fault_d = 1'b1;
                end
                if (fetch_en) begin
                    state_d    = S_WAIT;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = redirect ? target : pc_q;
                end
            end

            S_WAIT, S_DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (redirect) begin
                    pc_d = target;
                    if (misaligned) fault_d = 1'b1;
                end
                if (mem_ack) begin
                    state_d  = S_IDLE;
                    mem_rd_d = 1'b0;
                    cnt_d    = '0;
                    // DRAIN (or a redirect in the ack cycle) squashes the returning word.
                    if (state_q == S_WAIT && !redirect) begin
                        mem_data_d = mem_rdata;
                        ir_write_d = 1'b1;
                        pc_inst_d  = mem_addr_q;
                        pc_d       = mem_addr_q + STEP;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // This was the TIMEOUT-th cycle with mem_rd high and still no ack.
                    state_d  = S_IDLE;
                    mem_rd_d = 1'b0;
                    fault_d  = 1'b1;
                    cnt_d    = '0;
                end else if (redirect) begin
                    state_d = S_DRAIN;
                end
            end

            default: begin
                state_d  = S_IDLE;
                mem_rd_d = 1'b0;
                cnt_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_ADDR;
            pc_inst_q  <= RESET_ADDR;
            mem_addr_q <= RESET_ADDR;
            mem_rd_q   <= 1'b0;
            mem_data_q <= '0;
            ir_write_q <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_inst_q  <= pc_inst_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            mem_data_q <= mem_data_d;
            ir_write_q <= ir_write_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_rd      = mem_rd_q;
    assign memData     = mem_data_q;
    assign IRWrite     = ir_write_q;
    assign pc          = pc_q;
    assign pc_inst     = pc_inst_q;
    assign busy        = (state_q != S_IDLE);
    assign fault       = fault_q;
    assign dbg_state_o = state_q;

endmodule
